// File: rtl/fault_mon_pkg.sv
// fault_mon_pkg: shared state encoding, log-flag bit positions and the
// mismatch log record layout for the ALU fault monitor.
// The record fields are sized for the widest supported configuration
// (CNT_W <= REC_CNT_W, DATA_W <= REC_DATA_W); narrower instances zero-extend.
package fault_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_DETECTED  = 2'd2,
        ST_SATURATED = 2'd3
    } mon_state_e;

    localparam int FLAG_RES_BIT  = 0;
    localparam int FLAG_ZERO_BIT = 1;

    localparam int REC_CNT_W  = 16;
    localparam int REC_DATA_W = 32;

    typedef struct packed {
        logic [REC_CNT_W-1:0]  cycle;
        logic [REC_DATA_W-1:0] gold;
        logic [REC_DATA_W-1:0] fault;
        logic [1:0]            flags;
    } log_rec_t;

    // Assemble the flags field from the two mismatch causes.
    function automatic logic [1:0] make_flags(input logic res_mis, input logic zero_mis);
        logic [1:0] f;
        f                = 2'b00;
        f[FLAG_RES_BIT]  = res_mis;
        f[FLAG_ZERO_BIT] = zero_mis;
        return f;
    endfunction

endpackage

// File: rtl/fault_mon_fifo.sv
// fault_mon_fifo: small synchronous FIFO of mismatch log records.
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle; push_ok tells the caller whether the record was taken.
module fault_mon_fifo
    import fault_mon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  log_rec_t wr_rec,
    output log_rec_t head_rec,
    output logic     empty,
    output logic     full,
    output logic     push_ok
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    log_rec_t      mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          pop_s;

    assign empty    = (count_r == CNT_ZERO);
    assign full     = (count_r == CNT_FULL);
    assign pop_s    = pop & ~empty;
    assign push_ok  = push & (~full | pop_s);
    assign head_rec = mem_r[rd_ptr_r];

    // Write side: store accepted records; pointer wraps with the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= PTR_ZERO;
        end else if (push_ok) begin
            mem_r[wr_ptr_r] <= wr_rec;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
        end
    end

    // Read side: advance the head on a pop of a non-empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= PTR_ZERO;
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Occupancy tracking; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else begin
            case ({push_ok, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_fault_monitor.sv
// alu_fault_monitor: aligns the golden ALU sample with the registered faulty
// ALU output, compares them, counts mismatches, keeps sticky status and logs
// mismatch records in a FIFO drained through a valid/ready handshake.
// Optional build macro FAULT_MON_FLAG_CMP_EN also compares the Zero flags.
module alu_fault_monitor
    import fault_mon_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ALIGN_DLY  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] gold_result,
    input  logic              gold_zero,
    input  logic [DATA_W-1:0] fault_result,
    input  logic              fault_zero,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [CNT_W-1:0]  log_cycle,
    output logic [DATA_W-1:0] log_gold,
    output logic [DATA_W-1:0] log_fault,
    output logic [1:0]        log_flags,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [CNT_W-1:0]  first_fault_cycle,
    output logic              fault_detected,
    output logic              overflow,
    output logic [1:0]        state
);

    localparam int              PIPE_W   = DATA_W + 2;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic              srst_s;
    logic              aligned_valid_s;
    logic              aligned_zero_s;
    logic [DATA_W-1:0] aligned_gold_s;
    logic              q_s;
    logic              res_mis_s;
    logic              zero_mis_s;
    logic              mism_s;
    logic              push_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [CNT_W-1:0]  mcnt_next_s;
    mon_state_e        state_next_s;
    log_rec_t          wr_rec_s;
    log_rec_t          head_s;

    mon_state_e        state_r;
    logic [CNT_W-1:0]  sample_count_r;
    logic [CNT_W-1:0]  mismatch_count_r;
    logic [CNT_W-1:0]  first_fault_cycle_r;
    logic              fault_detected_r;
    logic              overflow_r;

    assign srst_s = rst | clear;

    generate
        if (ALIGN_DLY == 0) begin : g_no_align
            assign aligned_valid_s = in_valid;
            assign aligned_zero_s  = gold_zero;
            assign aligned_gold_s  = gold_result;
        end else begin : g_align
            logic [PIPE_W-1:0] pipe_r [ALIGN_DLY];

            // Delay the golden sample so it meets the registered faulty result.
            always_ff @(posedge clk) begin
                if (srst_s) begin
                    for (int i = 0; i < ALIGN_DLY; i++) begin
                        pipe_r[i] <= {PIPE_W{1'b0}};
                    end
                end else begin
                    pipe_r[0] <= {in_valid, gold_zero, gold_result};
                    for (int i = 1; i < ALIGN_DLY; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign {aligned_valid_s, aligned_zero_s, aligned_gold_s} = pipe_r[ALIGN_DLY-1];
        end
    endgenerate

`ifdef FAULT_MON_FLAG_CMP_EN
    assign zero_mis_s = q_s & (aligned_zero_s != fault_zero);
`else
    // Zero flags are not compared in this build; keep the ports connected.
    logic unused_zero_s;
    assign unused_zero_s = aligned_zero_s ^ fault_zero;
    assign zero_mis_s    = 1'b0;
`endif

    // Qualified compare of the aligned golden sample against the faulty result.
    always_comb begin
        q_s       = aligned_valid_s & en;
        res_mis_s = q_s & (aligned_gold_s != fault_result);
        mism_s    = res_mis_s | zero_mis_s;
        push_s    = mism_s & (state_r != ST_SATURATED);
        pop_s     = ~fifo_empty_s & log_ready;
        if (mismatch_count_r == CNT_MAX) begin
            mcnt_next_s = mismatch_count_r;
        end else begin
            mcnt_next_s = mismatch_count_r + CNT_ONE;
        end
        wr_rec_s.cycle = REC_CNT_W'(sample_count_r);
        wr_rec_s.gold  = REC_DATA_W'(aligned_gold_s);
        wr_rec_s.fault = REC_DATA_W'(fault_result);
        wr_rec_s.flags = make_flags(res_mis_s, zero_mis_s);
    end

    // Next-state logic; a disabled monitor holds its state.
    always_comb begin
        state_next_s = state_r;
        if (en) begin
            case (state_r)
                ST_IDLE: begin
                    if (mism_s) state_next_s = ST_DETECTED;
                    else        state_next_s = ST_ARMED;
                end
                ST_ARMED: begin
                    if (mism_s) state_next_s = ST_DETECTED;
                    else        state_next_s = ST_ARMED;
                end
                ST_DETECTED: begin
                    if (mism_s && (mcnt_next_s == CNT_MAX)) state_next_s = ST_SATURATED;
                    else                                    state_next_s = ST_DETECTED;
                end
                ST_SATURATED: state_next_s = ST_SATURATED;
                default:      state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Counters, sticky status and FSM register; pre-increment sample index is logged.
    always_ff @(posedge clk) begin
        if (srst_s) begin
            state_r             <= ST_IDLE;
            sample_count_r      <= CNT_ZERO;
            mismatch_count_r    <= CNT_ZERO;
            first_fault_cycle_r <= CNT_ZERO;
            fault_detected_r    <= 1'b0;
            overflow_r          <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (q_s && (sample_count_r != CNT_MAX)) begin
                sample_count_r <= sample_count_r + CNT_ONE;
            end
            if (mism_s) begin
                mismatch_count_r <= mcnt_next_s;
                fault_detected_r <= 1'b1;
                if (!fault_detected_r) begin
                    first_fault_cycle_r <= sample_count_r;
                end
            end
            if (push_s && !push_ok_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    fault_mon_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (srst_s),
        .push     (push_s),
        .pop      (pop_s),
        .wr_rec   (wr_rec_s),
        .head_rec (head_s),
        .empty    (fifo_empty_s),
        .full     (fifo_full_s),
        .push_ok  (push_ok_s)
    );

    assign log_valid         = ~fifo_empty_s;
    assign log_cycle         = head_s.cycle[CNT_W-1:0];
    assign log_gold          = head_s.gold[DATA_W-1:0];
    assign log_fault         = head_s.fault[DATA_W-1:0];
    assign log_flags         = head_s.flags;
    assign sample_count      = sample_count_r;
    assign mismatch_count    = mismatch_count_r;
    assign first_fault_cycle = first_fault_cycle_r;
    assign fault_detected    = fault_detected_r;
    assign overflow          = overflow_r;
    assign state             = state_r;

endmodule

// File: tb/tb_alu_fault_monitor.sv
// tb_alu_fault_monitor: randomized and directed stimulus for alu_fault_monitor.
// A behavioural model updated on every rising edge predicts the status outputs
// and pushes expected log records into a queue; a monitor on the falling edge
// compares status and pops/compares the log head on each handshake.
module tb_alu_fault_monitor;

    localparam int DATA_W     = 32;
    localparam int ALIGN_DLY  = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, en, clear, in_valid, gold_zero, fault_zero, log_ready;
    logic [DATA_W-1:0] gold_result, fault_result;
    logic              log_valid, fault_detected, overflow;
    logic [CNT_W-1:0]  log_cycle, sample_count, mismatch_count, first_fault_cycle;
    logic [DATA_W-1:0] log_gold, log_fault;
    logic [1:0]        log_flags, state;

    always #5 clk = ~clk;

    alu_fault_monitor #(
        .DATA_W(DATA_W), .ALIGN_DLY(ALIGN_DLY), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .in_valid(in_valid),
        .gold_result(gold_result), .gold_zero(gold_zero),
        .fault_result(fault_result), .fault_zero(fault_zero),
        .log_valid(log_valid), .log_ready(log_ready), .log_cycle(log_cycle),
        .log_gold(log_gold), .log_fault(log_fault), .log_flags(log_flags),
        .sample_count(sample_count), .mismatch_count(mismatch_count),
        .first_fault_cycle(first_fault_cycle), .fault_detected(fault_detected),
        .overflow(overflow), .state(state)
    );

    typedef struct { int unsigned cycle; logic [31:0] gold; logic [31:0] fault; logic [1:0] flags; } exp_rec_t;
    typedef struct { bit v; logic [31:0] g; bit z; } smp_t;

    exp_rec_t    exp_q[$];
    smp_t        pipe_q[$];
    int unsigned m_sample, m_mcount, m_first, m_occ, m_state;
    bit          m_det, m_ovf;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] pend_f;
    bit          pend_fz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per rising edge, using the inputs held across that edge.
    task automatic model_step();
        smp_t cur, al;
        bit q, rm, zm, mm, pop, push;
        if (rst || clear) begin
            m_sample = 0; m_mcount = 0; m_first = 0; m_occ = 0; m_state = 0;
            m_det = 0; m_ovf = 0;
            exp_q.delete();
            pipe_q.delete();
            for (int i = 0; i < ALIGN_DLY; i++) pipe_q.push_back('{1'b0, 32'd0, 1'b0});
            return;
        end
        cur.v = in_valid; cur.g = gold_result; cur.z = gold_zero;
        pipe_q.push_back(cur);
        al = pipe_q.pop_front();
        q  = al.v && en;
        rm = q && (al.g != fault_result);
`ifdef FAULT_MON_FLAG_CMP_EN
        zm = q && (al.z != fault_zero);
`else
        zm = 1'b0;
`endif
        mm   = rm || zm;
        pop  = (m_occ > 0) && log_ready;
        push = mm && (m_state != 3);
        if (push) begin
            if (m_occ < FIFO_DEPTH || pop) begin
                exp_q.push_back('{m_sample, al.g, fault_result, {zm, rm}});
                m_occ++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) m_occ--;
        if (mm) begin
            if (!m_det) m_first = m_sample;
            m_det = 1'b1;
            if (m_mcount < CNT_MAX) m_mcount++;
        end
        if (en) begin
            case (m_state)
                0: m_state = mm ? 2 : 1;
                1: if (mm) m_state = 2;
                2: if (mm && m_mcount == CNT_MAX) m_state = 3;
                default: ;
            endcase
        end
        if (q && m_sample < CNT_MAX) m_sample++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compare status every cycle; compare the head record while valid
    // and retire it from the scoreboard when the handshake completes.
    initial forever begin
        @(negedge clk);
        check("sample_count", sample_count, m_sample);
        check("mismatch_count", mismatch_count, m_mcount);
        check("first_fault_cycle", first_fault_cycle, m_first);
        check("fault_detected", fault_detected, m_det);
        check("overflow", overflow, m_ovf);
        check("state", state, m_state);
        check("log_valid", log_valid, exp_q.size() != 0);
        if (log_valid && exp_q.size() != 0) begin
            check("log_cycle", log_cycle, exp_q[0].cycle);
            check("log_gold", log_gold, exp_q[0].gold);
            check("log_fault", log_fault, exp_q[0].fault);
            check("log_flags", log_flags, exp_q[0].flags);
            if (log_ready) void'(exp_q.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a golden sample now and its faulty counterpart one cycle later.
    task automatic smp(input bit v, input logic [31:0] g, input logic [31:0] f, input bit gz, input bit fz);
        in_valid     = v;
        gold_result  = g;
        gold_zero    = gz;
        fault_result = pend_f;
        fault_zero   = pend_fz;
        pend_f       = f;
        pend_fz      = fz;
        cyc();
    endtask

    task automatic rnd_smp(input int mis_pct);
        logic [31:0] g, f;
        bit gz, fz;
        g = $urandom;
        if ($urandom_range(0, 3) == 0) g = $urandom_range(0, 3);
        f  = ($urandom_range(0, 99) < mis_pct) ? (g ^ ($urandom | 32'd1)) : g;
        gz = $urandom_range(0, 1);
        fz = ($urandom_range(0, 9) == 0) ? ~gz : gz;
        smp($urandom_range(0, 9) != 0, g, f, gz, fz);
    endtask

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b0; pend_f = 32'd0; pend_fz = 1'b0;
        cyc();
        clear = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sample_count"}, sample_count, 0);
        check({tag, "_mismatch_count"}, mismatch_count, 0);
        check({tag, "_first_fault"}, first_fault_cycle, 0);
        check({tag, "_fault_detected"}, fault_detected, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_state"}, state, 0);
        check({tag, "_log_valid"}, log_valid, 0);
        check({tag, "_log_cycle"}, log_cycle, 0);
        check({tag, "_log_gold"}, log_gold, 0);
        check({tag, "_log_fault"}, log_fault, 0);
        check({tag, "_log_flags"}, log_flags, 0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; en = 1'b0; in_valid = 1'b0; log_ready = 1'b0;
        gold_result = 32'd0; gold_zero = 1'b0; fault_result = 32'd0; fault_zero = 1'b0;
        pend_f = 32'd0; pend_fz = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        check_zero("por");

        // Traffic, then reset for two cycles mid-stream.
        en = 1'b1; log_ready = 1'b1;
        for (int i = 0; i < 20; i++) rnd_smp(40);
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        check_zero("rst_mid");

        // Matching stream of five samples.
        do_clear();
        for (int i = 0; i < 5; i++) smp(1'b1, 32'h5, 32'h5, 1'b0, 1'b0);
        smp(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("match_sample_count", sample_count, 5);
        check("match_mismatch_count", mismatch_count, 0);
        check("match_state", state, 1);
        check("match_fault_detected", fault_detected, 0);

        // Single mismatch at sample 2.
        do_clear();
        log_ready = 1'b0;
        smp(1'b1, 32'h5, 32'h5, 1'b0, 1'b0);
        smp(1'b1, 32'h7, 32'h7, 1'b0, 1'b0);
        smp(1'b1, 32'hF, 32'h3, 1'b0, 1'b0);
        smp(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("single_mismatch_count", mismatch_count, 1);
        check("single_fault_detected", fault_detected, 1);
        check("single_first_fault", first_fault_cycle, 2);
        check("single_state", state, 2);
        check("single_log_valid", log_valid, 1);
        check("single_log_gold", log_gold, 32'hF);
        check("single_log_fault", log_fault, 32'h3);
        check("single_log_flags", log_flags, 2'b01);

        // Overflow: six mismatches into a four-entry log, then drain in order.
        do_clear();
        for (int i = 0; i < 6; i++) smp(1'b1, 32'h100 + i, 32'h200 + i, 1'b0, 1'b0);
        smp(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("ovf_overflow", overflow, 1);
        check("ovf_mismatch_count", mismatch_count, 6);
        log_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain_cycle", log_cycle, k);
            smp(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        check("ovf_drained_valid", log_valid, 0);

        // Full log with push and pop in the same cycle.
        do_clear();
        log_ready = 1'b0;
        for (int i = 0; i < 5; i++) smp(1'b1, 32'h10 + i, 32'h20 + i, 1'b0, 1'b0);
        log_ready = 1'b1;
        smp(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        log_ready = 1'b0;
        check("pp_overflow", overflow, 0);
        check("pp_mismatch_count", mismatch_count, 5);
        check("pp_head_cycle", log_cycle, 1);
        log_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check("pp_drain_cycle", log_cycle, k);
            smp(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        check("pp_drained_valid", log_valid, 0);

        // Randomized traffic with random enable, back-pressure and occasional clear.
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            log_ready = $urandom_range(0, 1);
            clear     = ($urandom_range(0, 199) == 0);
            rnd_smp(30);
        end
        clear = 1'b0; en = 1'b1;

        // Saturate the mismatch counter.
        do_clear();
        log_ready = 1'b0;
        for (int i = 0; i < CNT_MAX + 5; i++) smp(1'b1, i, ~i, 1'b0, 1'b0);
        smp(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("sat_mismatch_count", mismatch_count, CNT_MAX);
        check("sat_state", state, 3);
        check("sat_overflow", overflow, 1);
        log_ready = 1'b1;
        repeat (4) smp(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        smp(1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
        smp(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("sat_no_push", log_valid, 0);
        check("sat_state_hold", state, 3);
        do_clear();
        check_zero("sat_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
